lowbit_scan_unit: RTL and testbench
===================================

Name: lowbit_scan_unit

Overview:
- Parametrised, multi-cycle bit-scan unit; the sequential successor of the combinational lowest-set-bit block.
- Computes one of four bit-scan functions on a WIDTH-bit operand: trailing-zero count (lowbit index), highest-set-bit index, population count, leading-zero count.
- Sits beside the multiply/divide unit in the EX stage and uses the same start/busy handshake, so the hazard unit stalls on busy.
- Examines STEP bits per cycle and has a fixed latency.

Parameters:
- WIDTH, 32, operand width. Must be a power of two, 4..64.
- STEP, 4, bits examined per cycle. Must be a power of two and divide WIDTH.
- N (localparam), WIDTH/STEP, scan cycles per operation.
- RES_W (localparam), clog2(WIDTH)+1, result width. It must hold the value WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation. Sampled only when busy=0.
- mode  input  2  function select: 00 ctz, 01 msb index, 10 popcount, 11 clz. Captured with start.
- din  input  WIDTH  operand. Captured with start.
- busy  output  1  operation in progress.
- done  output  1  single-cycle pulse marking result update.
- result  output  RES_W  registered result. Holds its value between completions.
- found  output  1  registered: 1 if the captured operand was nonzero.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - busy=0, done=0, result=0, found=0.
  - Cycle counter and internal operand/accumulator registers are cleared.
  - reset has priority over all other inputs, including start in the same cycle.
- States: IDLE, SCAN.
- IDLE:
  - On an edge with start=1, capture din and mode into internal registers, clear the counter and accumulators, and go to SCAN (busy=1 from the next cycle).
  - done is 0 in every IDLE cycle except the cycle immediately after a completion.
- SCAN, each cycle: examine STEP bits of the captured operand.
  - Chunk order is LSB-first for ctz, msb-index and popcount; MSB-first for clz.
  - Then increment the counter.
  - ctz / clz: accumulate zero count until the first 1 is seen in scan order. After that, freeze the count and set an internal hit flag.
  - msb index: record the index of the highest 1 seen so far. Each chunk containing a 1 overwrites the record.
  - popcount: add the number of ones in the chunk. Accumulator width is RES_W.
- Completion: on the edge ending the N-th SCAN cycle:
  - busy<=0, done<=1 for exactly one cycle;
  - result<=final value;
  - found<=(operand != 0);
  - state goes to IDLE.
- Latency: start sampled at edge E0 → busy=1 during cycles E0..E(N) → result/done valid after edge E(N).
  - Fixed N+1 edges; no early exit on a hit.
  - Defaults: N=8.
- Zero operand: ctz=WIDTH, msb index=WIDTH with found=0, popcount=0, clz=WIDTH.
- result, found and the captured operand do not change during SCAN. din and mode may change freely while busy.
- start while busy=1 is ignored: no restart and no queueing.
- start in the done cycle (busy=0) is accepted. A new operation begins with no idle gap, and done drops on the next edge.
- reset mid-SCAN aborts the operation immediately: no done pulse, and result is cleared to 0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then idle 5 cycles → busy=0, done=0, result=0, found=0 throughout.
- din=0x00000028, one start per mode, each issued in the done cycle of the previous op → results 3 (ctz), 5 (msb), 2 (pop), 26 (clz). Each done arrives exactly 9 edges after its start, and busy has no gap between ops.
- din=0x00000000, all modes → 32, 32 (found=0), 0, 32. din=0x80000000 → 31, 31, 1, 0. din=0xFFFFFFFF → 0, 31, 32, 0.
- start with din=0x00000100, mode 00; at cycle 3 change din/mode and pulse start again → ignored; result=8 after edge 9, and only one done pulse.
- Assert reset at cycle 4 of SCAN with a previous result of 5 → next cycle busy=0, result=0, no done pulse. A fresh start then completes normally.
- Parameter sweep (WIDTH=16, STEP=16, N=1) with din=0x0400, mode 00 → result=10 after 2 edges, done for one cycle; zero operand → 16.

Source files
------------

// File: rtl/lowbit_scan_unit.sv
// lowbit_scan_unit: multi-cycle bit-scan unit (ctz, msb index, popcount, clz).
// Latency: start sampled at edge E0; result/done update at edge E(N), N = WIDTH/STEP.
// Backpressure: start is ignored while busy; no queueing. Start in the done cycle is accepted.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   start, mode, din - request; mode/din captured with start (00 ctz, 01 msb, 10 pop, 11 clz)
//   busy            - operation in progress
//   done            - one-cycle pulse when result/found update
//   result, found   - registered result; found=1 if the captured operand was nonzero
module lowbit_scan_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int N     = WIDTH / STEP,
  localparam int RES_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             found
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] MODE_CTZ = 2'b00;
  localparam logic [1:0] MODE_MSB = 2'b01;
  localparam logic [1:0] MODE_POP = 2'b10;
  localparam logic [1:0] MODE_CLZ = 2'b11;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [1:0]       mode_q, mode_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic             hit_q, hit_d;
  logic             done_q, done_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             found_q, found_d;

  logic [CNT_W-1:0] chunk_idx;
  logic [STEP-1:0]  chunk;
  logic [RES_W-1:0] chunk_base;
  logic [RES_W-1:0] chunk_tz;
  logic [RES_W-1:0] chunk_lz;
  logic [RES_W-1:0] chunk_hi;
  logic [RES_W-1:0] chunk_ones;

  // Per-cycle chunk analysis. clz walks chunks from the top, everything
  // else walks from bit 0 upward.
  always_comb begin
    chunk_idx  = (mode_q == MODE_CLZ) ? (CNT_W'(N - 1) - cnt_q) : cnt_q;
    chunk      = STEP'(op_q >> (int'(chunk_idx) * STEP));
    chunk_base = RES_W'(int'(chunk_idx) * STEP);
    chunk_tz   = '0;
    chunk_lz   = '0;
    chunk_hi   = '0;
    chunk_ones = '0;
    // Descending loop: the lowest set bit is the last one written.
    for (int i = STEP - 1; i >= 0; i--) begin
      if (chunk[i]) chunk_tz = RES_W'(i);
    end
    // Ascending loop: the highest set bit is the last one written.
    for (int i = 0; i < STEP; i++) begin
      if (chunk[i]) begin
        chunk_hi = RES_W'(i);
        chunk_lz = RES_W'(STEP - 1 - i);
      end
      chunk_ones = chunk_ones + RES_W'(chunk[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    hit_d    = hit_q;
    done_d   = 1'b0;
    result_d = result_q;
    found_d  = found_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = din;
          mode_d  = mode;
          cnt_d   = '0;
          acc_d   = '0;
          hit_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + CNT_W'(1);
        case (mode_q)
          MODE_CTZ, MODE_CLZ: begin
            // Zero count freezes once the first 1 in scan order is seen.
            if (!hit_q) begin
              if (chunk == '0) begin
                acc_d = acc_q + RES_W'(STEP);
              end else begin
                acc_d = acc_q + ((mode_q == MODE_CLZ) ? chunk_lz : chunk_tz);
                hit_d = 1'b1;
              end
            end
          end
          MODE_MSB: begin
            // LSB-first order: the last nonzero chunk holds the highest 1.
            if (chunk != '0) begin
              acc_d = chunk_base + chunk_hi;
              hit_d = 1'b1;
            end
          end
          default: begin
            acc_d = acc_q + chunk_ones;
          end
        endcase

        if (cnt_q == CNT_W'(N - 1)) begin
          state_d  = IDLE;
          cnt_d    = '0;
          done_d   = 1'b1;
          found_d  = (op_q != '0);
          // msb of a zero operand reports WIDTH; ctz/clz reach WIDTH naturally.
          result_d = ((mode_q == MODE_MSB) && !hit_d) ? RES_W'(WIDTH) : acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mode_q   <= '0;
      acc_q    <= '0;
      hit_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      hit_q    <= hit_d;
      done_q   <= done_d;
      result_q <= result_d;
      found_q  <= found_d;
    end
  end

  assign busy   = (state_q == SCAN);
  assign done   = done_q;
  assign result = result_q;
  assign found  = found_q;

endmodule

// File: tb/tb_lowbit_scan_unit.sv
// Testbench for lowbit_scan_unit: directed scenarios plus randomized operations
// against a whole-word reference model; also a WIDTH=16/STEP=16 instance.
module tb_lowbit_scan_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] din = '0;
  logic        busy, done, found;
  logic [5:0]  result;

  logic        start_n = 1'b0;
  logic [1:0]  mode_n = 2'b00;
  logic [15:0] din_n = '0;
  logic        busy_n, done_n, found_n;
  logic [4:0]  result_n;

  int vec = 0;
  int errs = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  lowbit_scan_unit #(.WIDTH(32), .STEP(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .din(din),
    .busy(busy), .done(done), .result(result), .found(found)
  );

  lowbit_scan_unit #(.WIDTH(16), .STEP(16)) u_narrow (
    .clk(clk), .reset(reset), .start(start_n), .mode(mode_n), .din(din_n),
    .busy(busy_n), .done(done_n), .result(result_n), .found(found_n)
  );

  // Whole-word reference: ctz, msb index, popcount, clz; zero operand -> WIDTH (pop -> 0).
  function automatic logic [31:0] model_scan(input logic [1:0] m, input logic [63:0] v, input int w);
    int r;
    r = (m == 2'b10) ? 0 : w;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00: if (v[i] && r == w) r = i;
        2'b01: if (v[i]) r = i;
        2'b10: if (v[i]) r = r + 1;
        default: if (v[i]) r = w - 1 - i;
      endcase
    end
    return r;
  endfunction

  // Releases start after the accepting edge and waits (bounded) for done.
  // edges counts negedges since the start was driven: done at edges==N+1.
  task automatic wait_done(output int edges);
    @(negedge clk);
    edges = 1;
    start = 1'b0;
    while (!done && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic wait_done_n(output int edges);
    @(negedge clk);
    edges = 1;
    start_n = 1'b0;
    while (!done_n && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vec++;
      if ({busy, done, result, found} !== 9'b0) begin
        errs++;
        $display("FAIL reset_idle cyc%0d: busy=%b done=%b result=%0d found=%b, want all 0", c, busy, done, result, found);
      end
      vec++;
      if ({busy_n, done_n, result_n, found_n} !== 8'b0) begin
        errs++;
        $display("FAIL reset_idle_narrow cyc%0d: busy=%b done=%b result=%0d found=%b, want all 0", c, busy_n, done_n, result_n, found_n);
      end
    end
    // reset wins over a simultaneous start
    reset = 1'b1; start = 1'b1; din = 32'hFF;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_priority: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    int edges;
    din = 32'h28; mode = 2'b00; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = model_scan(2'(k), 64'(din), 32);
      wait_done(edges);
      vec++;
      if (edges != 9) begin
        errs++;
        $display("FAIL b2b_latency mode%0d: done after %0d edges, want 9", k, edges);
      end
      vec++;
      if (result !== e[5:0] || found !== 1'b1 || busy !== 1'b0) begin
        errs++;
        $display("FAIL b2b_result mode%0d: result=%0d found=%b busy=%b, want %0d 1 0", k, result, found, busy, e);
      end
      last_exp = e;
      if (k < 3) begin
        start = 1'b1;
        mode = 2'(k + 1);
        @(negedge clk);
        vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errs++;
          $display("FAIL b2b_nogap mode%0d: busy=%b done=%b, want 1 0", k + 1, busy, done);
        end
        // Already one edge into the next op; wait_done will add the rest.
        start = 1'b0;
        edges = 1;
        while (!done && edges < 40) begin
          @(negedge clk);
          edges++;
        end
        start = 1'b1;
        // Rewind: the check for this op is done here rather than at loop top.
        e = model_scan(2'(k + 1), 64'(din), 32);
        vec++;
        if (edges != 9 || result !== e[5:0]) begin
          errs++;
          $display("FAIL b2b_chain mode%0d: edges=%0d result=%0d, want 9 %0d", k + 1, edges, result, e);
        end
        last_exp = e;
        start = 1'b0;
        break;
      end
    end
    @(negedge clk);
    vec++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL b2b_done_pulse: done=%b, want 0", done);
    end
  endtask

  // Remaining modes of the 0x28 chain, each issued in the done cycle of the previous op.
  task automatic test_chain_rest;
    logic [31:0] e;
    int edges;
    din = 32'h28;
    for (int k = 2; k < 4; k++) begin
      mode = 2'(k); start = 1'b1;
      e = model_scan(2'(k), 64'(din), 32);
      wait_done(edges);
      vec++;
      if (edges != 9 || result !== e[5:0]) begin
        errs++;
        $display("FAIL chain mode%0d: edges=%0d result=%0d, want 9 %0d", k, edges, result, e);
      end
      last_exp = e;
    end
  endtask

  task automatic test_corners;
    logic [31:0] pats [3];
    logic [31:0] e;
    int edges;
    pats[0] = 32'h0; pats[1] = 32'h8000_0000; pats[2] = 32'hFFFF_FFFF;
    for (int p = 0; p < 3; p++) begin
      for (int m = 0; m < 4; m++) begin
        din = pats[p]; mode = 2'(m); start = 1'b1;
        e = model_scan(2'(m), 64'(pats[p]), 32);
        wait_done(edges);
        vec++;
        if (edges != 9 || result !== e[5:0] || found !== (pats[p] != 0)) begin
          errs++;
          $display("FAIL corner din=%h mode%0d: edges=%0d result=%0d found=%b, want 9 %0d %b",
                   pats[p], m, edges, result, found, e, pats[p] != 0);
        end
        last_exp = e;
      end
    end
  endtask

  task automatic test_ignore_start;
    int edges, dones, first;
    logic [31:0] held;
    held = last_exp;
    din = 32'h100; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    edges = 1; dones = 0; first = 0;
    while (edges < 16) begin
      if (edges == 3) begin
        start = 1'b1; mode = 2'b11; din = $urandom;
      end else begin
        start = 1'b0;
      end
      if (busy) begin
        vec++;
        if (result !== held[5:0]) begin
          errs++;
          $display("FAIL ignore_hold edge%0d: result=%0d, want %0d", edges, result, held);
        end
      end
      @(negedge clk);
      edges++;
      if (done) begin
        dones++;
        if (first == 0) first = edges;
      end
    end
    vec++;
    if (first != 9 || dones != 1 || result !== 6'd8 || busy !== 1'b0) begin
      errs++;
      $display("FAIL ignore_start: first_done=%0d dones=%0d result=%0d busy=%b, want 9 1 8 0", first, dones, result, busy);
    end
    last_exp = 8;
  endtask

  task automatic test_reset_abort;
    logic [31:0] e;
    int edges, dones;
    din = 32'h28; mode = 2'b01; start = 1'b1;
    wait_done(edges);
    vec++;
    if (result !== 6'd5) begin
      errs++;
      $display("FAIL abort_setup: result=%0d, want 5", result);
    end
    din = $urandom | 32'h1; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec++;
    if (busy !== 1'b0 || result !== 6'd0 || done !== 1'b0 || found !== 1'b0) begin
      errs++;
      $display("FAIL abort_clear: busy=%b result=%0d done=%b found=%b, want 0 0 0 0", busy, result, done, found);
    end
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    vec++;
    if (dones != 0) begin
      errs++;
      $display("FAIL abort_no_done: %0d done pulses, want 0", dones);
    end
    din = $urandom; mode = 2'(($urandom_range(0, 3))); start = 1'b1;
    e = model_scan(mode, 64'(din), 32);
    wait_done(edges);
    vec++;
    if (edges != 9 || result !== e[5:0] || found !== (din != 0)) begin
      errs++;
      $display("FAIL abort_fresh: edges=%0d result=%0d found=%b, want 9 %0d %b", edges, result, found, e, din != 0);
    end
    last_exp = e;
  endtask

  task automatic test_random;
    logic [31:0] v, e;
    logic [1:0] m;
    int edges;
    for (int n = 0; n < 40; n++) begin
      v = $urandom;
      case ($urandom_range(0, 3))
        0: v = v << $urandom_range(0, 31);
        1: v = v >> $urandom_range(0, 31);
        2: v = 32'h1 << $urandom_range(0, 31);
        default: ;
      endcase
      m = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      din = v; mode = m; start = 1'b1;
      e = model_scan(m, 64'(v), 32);
      wait_done(edges);
      vec++;
      if (edges != 9 || result !== e[5:0] || found !== (v != 0)) begin
        errs++;
        $display("FAIL random#%0d din=%h mode%0d: edges=%0d result=%0d found=%b, want 9 %0d %b",
                 n, v, m, edges, result, found, e, v != 0);
      end
    end
  endtask

  task automatic test_narrow;
    logic [31:0] e;
    logic [15:0] v;
    int edges;
    din_n = 16'h0400; mode_n = 2'b00; start_n = 1'b1;
    wait_done_n(edges);
    vec++;
    if (edges != 2 || result_n !== 5'd10 || found_n !== 1'b1) begin
      errs++;
      $display("FAIL narrow_ctz: edges=%0d result=%0d found=%b, want 2 10 1", edges, result_n, found_n);
    end
    @(negedge clk);
    vec++;
    if (done_n !== 1'b0) begin
      errs++;
      $display("FAIL narrow_done_pulse: done=%b, want 0", done_n);
    end
    for (int n = 0; n < 12; n++) begin
      v = (n < 4) ? 16'h0 : 16'($urandom);
      mode_n = 2'(n % 4); din_n = v; start_n = 1'b1;
      e = model_scan(mode_n, 64'(v), 16);
      wait_done_n(edges);
      vec++;
      if (edges != 2 || result_n !== e[4:0] || found_n !== (v != 0)) begin
        errs++;
        $display("FAIL narrow#%0d din=%h mode%0d: edges=%0d result=%0d found=%b, want 2 %0d %b",
                 n, v, n % 4, edges, result_n, found_n, e, v != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_chain_rest();
    test_corners();
    test_ignore_start();
    test_reset_abort();
    test_random();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
